// File: rtl/lsu_stb_alloc_ctl.sv
// Per-thread store-buffer sequencer: allocates STB entries at M, retracts a W-flushed allocation, issues to PCX in order, frees on CPX ack.
// Latency: write enable is combinational in the alloc cycle; an entry is issuable two cycles after allocation; pointers and count are registered.
// Backpressure: alloc is refused while full (sticky err); issue valid/ptr hold until pcx_grant; ack frees only already-issued entries.
//
// Ports:
//   rclk, arst                  core clock; asynchronous active-high reset
//   st_vld_m                    store in M requests an entry
//   st_flush_w                  store allocated last cycle is killed at W
//   pcx_grant, cpx_st_ack       PCX accept of presented entry; CPX store ack
//   stb_clk_en_l[DEPTH-1:0]     one-hot-low entry write enable (all 1 = none)
//   stb_wptr, stb_issue_vld/ptr next alloc slot; issue handshake to PCX
//   stb_cnt, stb_full/empty     occupancy including the pending entry
//   stb_err                     sticky protocol-violation flag
module lsu_stb_alloc_ctl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             rclk,
    input  logic             arst,
    input  logic             st_vld_m,
    input  logic             st_flush_w,
    input  logic             pcx_grant,
    input  logic             cpx_st_ack,
    output logic [DEPTH-1:0] stb_clk_en_l,
    output logic [PTR_W-1:0] stb_wptr,
    output logic             stb_issue_vld,
    output logic [PTR_W-1:0] stb_issue_ptr,
    output logic [PTR_W:0]   stb_cnt,
    output logic             stb_full,
    output logic             stb_empty,
    output logic             stb_err
);

    localparam int PW = PTR_W + 1;

    // Pointers carry one extra wrap bit so (wptr - iptr) is a true distance.
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] iptr_q, iptr_d;
    logic [PW-1:0] dptr_q, dptr_d;
    logic [PW-1:0] cnt_q,  cnt_d;
    logic          pend_q, pend_d;
    logic          err_q,  err_d;

    logic             full;
    logic             alloc;
    logic             flush;
    logic             grant_fire;
    logic             ack_ok;
    logic [PTR_W-1:0] en_idx;
    logic [PW-1:0]    cu;

    always_comb begin
        full       = (cnt_q == PW'(DEPTH));
        // Gating with arst keeps every write enable inactive while in reset.
        alloc      = st_vld_m & ~full & ~arst;
        flush      = st_flush_w & pend_q;
        // On alloc+flush the new store reuses the slot being retracted.
        en_idx     = wptr_q[PTR_W-1:0] - PTR_W'(flush);
        // The pending (pre-W) entry is never offered to the PCX.
        cu         = wptr_q - iptr_q - PW'(pend_q);
        grant_fire = (cu != '0) & pcx_grant;
        ack_ok     = cpx_st_ack & (iptr_q != dptr_q);

        stb_clk_en_l = '1;
        if (alloc) begin
            stb_clk_en_l[en_idx] = 1'b0;
        end

        wptr_d = wptr_q;
        if (alloc && !flush) begin
            wptr_d = wptr_q + PW'(1);
        end else if (!alloc && flush) begin
            wptr_d = wptr_q - PW'(1);
        end

        iptr_d = grant_fire ? iptr_q + PW'(1) : iptr_q;
        dptr_d = ack_ok     ? dptr_q + PW'(1) : dptr_q;
        cnt_d  = cnt_q + PW'(alloc) - PW'(flush) - PW'(ack_ok);
        // A new alloc always becomes the pending entry, even when it replaces a flushed one.
        pend_d = alloc;
        err_d  = err_q
               | (st_vld_m & full)
               | (st_flush_w & ~pend_q)
               | (cpx_st_ack & ~ack_ok);
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            wptr_q <= '0;
            iptr_q <= '0;
            dptr_q <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            iptr_q <= iptr_d;
            dptr_q <= dptr_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign stb_wptr      = wptr_q[PTR_W-1:0];
    assign stb_issue_vld = (cu != '0);
    assign stb_issue_ptr = iptr_q[PTR_W-1:0];
    assign stb_cnt       = cnt_q;
    assign stb_full      = full;
    assign stb_empty     = (cnt_q == '0);
    assign stb_err       = err_q;

endmodule

// File: tb/tb_lsu_stb_alloc_ctl.sv
// Directed bench for the store-buffer sequencer with hand-computed expectations.
// Inputs change 1 time unit after rclk rises; outputs are checked mid-cycle.
// Every comparison goes through chk(); one summary line at the end.
module tb_lsu_stb_alloc_ctl;

    logic       rclk;
    logic       arst;
    logic       st_vld_m;
    logic       st_flush_w;
    logic       pcx_grant;
    logic       cpx_st_ack;
    logic [7:0] stb_clk_en_l;
    logic [2:0] stb_wptr;
    logic       stb_issue_vld;
    logic [2:0] stb_issue_ptr;
    logic [3:0] stb_cnt;
    logic       stb_full;
    logic       stb_empty;
    logic       stb_err;

    int n_chk;
    int n_err;

    lsu_stb_alloc_ctl #(.DEPTH(8), .PTR_W(3)) dut (
        .rclk          (rclk),
        .arst          (arst),
        .st_vld_m      (st_vld_m),
        .st_flush_w    (st_flush_w),
        .pcx_grant     (pcx_grant),
        .cpx_st_ack    (cpx_st_ack),
        .stb_clk_en_l  (stb_clk_en_l),
        .stb_wptr      (stb_wptr),
        .stb_issue_vld (stb_issue_vld),
        .stb_issue_ptr (stb_issue_ptr),
        .stb_cnt       (stb_cnt),
        .stb_full      (stb_full),
        .stb_empty     (stb_empty),
        .stb_err       (stb_err)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic g, input logic a);
        st_vld_m   = v;
        st_flush_w = f;
        pcx_grant  = g;
        cpx_st_ack = a;
        #3;
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        arst  = 1'b1;
        drive(0, 0, 0, 0);

        // Reset state
        chk("rst_en",    stb_clk_en_l,  8'hFF);
        chk("rst_cnt",   stb_cnt,       4'd0);
        chk("rst_vld",   stb_issue_vld, 1'b0);
        chk("rst_empty", stb_empty,     1'b1);
        chk("rst_full",  stb_full,      1'b0);
        chk("rst_err",   stb_err,       1'b0);
        do_reset();

        // 1: single alloc, issuable two cycles later
        drive(1, 0, 0, 0);
        chk("t1_en", stb_clk_en_l, 8'hFE);
        tick();
        drive(0, 0, 0, 0);
        chk("t1_wptr",  stb_wptr,      3'd1);
        chk("t1_cnt",   stb_cnt,       4'd1);
        chk("t1_vld1",  stb_issue_vld, 1'b0);
        chk("t1_en_off", stb_clk_en_l, 8'hFF);
        tick();
        drive(0, 0, 0, 0);
        chk("t1_vld2", stb_issue_vld, 1'b1);
        chk("t1_iptr", stb_issue_ptr, 3'd0);

        // 2: flush at W rolls back; alloc+flush reuses the slot
        do_reset();
        drive(1, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        chk("t2_wptr", stb_wptr, 3'd0);
        chk("t2_cnt",  stb_cnt,  4'd0);
        tick();
        drive(0, 0, 0, 0);
        chk("t2_novld", stb_issue_vld, 1'b0);
        chk("t2_err0",  stb_err,       1'b0);
        drive(1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0);
        chk("t2_en_reuse", stb_clk_en_l, 8'hFE);
        tick();
        drive(0, 0, 0, 0);
        chk("t2_wptr_keep", stb_wptr,      3'd1);
        chk("t2_cnt_keep",  stb_cnt,       4'd1);
        chk("t2_pend_vld",  stb_issue_vld, 1'b0);
        tick();
        drive(0, 0, 0, 0);
        chk("t2_vld", stb_issue_vld, 1'b1);
        chk("t2_err", stb_err,       1'b0);

        // 3: fill to 8, ninth store refused
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_en;
            exp_en = ~(8'd1 << i);
            drive(1, 0, 0, 0);
            chk($sformatf("t3_en%0d", i), stb_clk_en_l, exp_en);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("t3_full", stb_full, 1'b1);
        chk("t3_cnt",  stb_cnt,  4'd8);
        drive(1, 0, 0, 0);
        chk("t3_en_full", stb_clk_en_l, 8'hFF);
        tick();
        drive(0, 0, 0, 0);
        chk("t3_err",      stb_err,  1'b1);
        chk("t3_cnt_hold", stb_cnt,  4'd8);
        chk("t3_wptr",     stb_wptr, 3'd0);

        // 4: issue held while grant is low
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            chk($sformatf("t4_vld%0d", i), stb_issue_vld, 1'b1);
            chk($sformatf("t4_ptr%0d", i), stb_issue_ptr, 3'd0);
            tick();
        end
        drive(0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        chk("t4_ptr_adv", stb_issue_ptr, 3'd1);

        // 5: drain all, then wrap allocation
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("t5_vld_done", stb_issue_vld, 1'b0);
        chk("t5_ptr_wrap", stb_issue_ptr, 3'd0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("t5_cnt0",  stb_cnt,   4'd0);
        chk("t5_empty", stb_empty, 1'b1);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_en;
            exp_en = ~(8'd1 << i);
            drive(1, 0, 0, 0);
            chk($sformatf("t5_en%0d", i), stb_clk_en_l, exp_en);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("t5_wptr",   stb_wptr,  3'd3);
        chk("t5_cnt3",   stb_cnt,   4'd3);
        chk("t5_nempty", stb_empty, 1'b0);

        // 6: ack with nothing issued; async reset mid-fill
        do_reset();
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("t6_cnt", stb_cnt, 4'd0);
        chk("t6_err", stb_err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0);
        chk("t6_pre_vld", stb_issue_vld, 1'b1);
        arst = 1'b1;
        #1;
        chk("t6_arst_cnt",  stb_cnt,       4'd0);
        chk("t6_arst_wptr", stb_wptr,      3'd0);
        chk("t6_arst_vld",  stb_issue_vld, 1'b0);
        chk("t6_arst_en",   stb_clk_en_l,  8'hFF);
        chk("t6_arst_err",  stb_err,       1'b0);
        tick();
        chk("t6_hold_cnt", stb_cnt,      4'd0);
        chk("t6_hold_ptr", stb_issue_ptr, 3'd0);
        arst = 1'b0;
        drive(0, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
